// File: rtl/time_setter.sv
// Time-limit entry for time mode 2: debounced up/down/ok buttons edit a
// countdown limit, confirm publishes max_time with a one-cycle start pulse.
module time_setter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP            = 5,
    parameter int MIN_TIME        = 5,
    parameter int MAX_LIMIT       = 255,
    parameter int DEFAULT_TIME    = 60
) (
    input  logic       orig_clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    output logic [7:0] max_time,
    output logic       start,
    output logic       locked,
    output logic [3:0] set_hundreds,
    output logic [3:0] set_tens,
    output logic [3:0] set_ones
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [8:0] MIN9  = 9'(MIN_TIME);
    localparam logic [8:0] MAX9  = 9'(MAX_LIMIT);
    localparam logic [7:0] DEF8  = 8'(DEFAULT_TIME);

    typedef enum logic {EDIT, ARMED} state_t;

    state_t           state, state_n;
    logic [7:0]       edit_val, edit_n;
    logic [7:0]       max_n;
    logic             start_n;

    // bit 0 = up, bit 1 = down, bit 2 = ok
    logic [2:0]       raw;
    logic [2:0]       sync_a, sync_b;
    logic [2:0]       deb, deb_q;
    logic [CNT_W-1:0] cnt [3];
    logic [2:0]       press;

    assign raw   = {btn_ok, btn_down, btn_up};
    assign press = deb & ~deb_q;

    always_ff @(posedge orig_clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            deb_q  <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            deb_q  <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sync_b[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Nine-bit arithmetic so neither end of the range wraps.
    logic [8:0] up_sum;
    logic       dn_room;
    logic [7:0] inc_val, dec_val;

    assign up_sum  = {1'b0, edit_val} + STEP9;
    assign dn_room = {1'b0, edit_val} >= (MIN9 + STEP9);
    assign inc_val = (up_sum > MAX9) ? MAX9[7:0] : up_sum[7:0];
    assign dec_val = dn_room ? (edit_val - STEP9[7:0]) : MIN9[7:0];

    always_ff @(posedge orig_clk or posedge reset) begin
        if (reset) begin
            state    <= EDIT;
            edit_val <= DEF8;
            max_time <= DEF8;
            start    <= 1'b0;
        end else begin
            state    <= state_n;
            edit_val <= edit_n;
            max_time <= max_n;
            start    <= start_n;
        end
    end

    always_comb begin
        state_n = state;
        edit_n  = edit_val;
        max_n   = max_time;
        start_n = 1'b0;
        unique case (state)
            EDIT: begin
                if (press[2]) begin
                    max_n   = edit_val;
                    start_n = 1'b1;
                    state_n = ARMED;
                end else if (press[0] && !press[1]) begin
                    edit_n = inc_val;
                end else if (press[1] && !press[0]) begin
                    edit_n = dec_val;
                end
            end
            ARMED: begin
                if (press[2]) state_n = EDIT;
            end
            default: state_n = EDIT;
        endcase
    end

    assign locked       = (state == ARMED);
    assign set_hundreds = 4'(edit_val / 8'd100);
    assign set_tens     = 4'((edit_val % 8'd100) / 8'd10);
    assign set_ones     = 4'(edit_val % 8'd10);

endmodule
